// File: rtl/vec_addr_gen.sv
// Element address sequencer for MULF/SUMF: captures loop scalars,
// streams operand-address pairs, then issues the result address.
module vec_addr_gen #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] i_in,
    input  logic [AW-1:0] j_in,
    input  logic [AW-1:0] n_in,
    input  logic [AW-1:0] base_a,
    input  logic [AW-1:0] base_b,
    input  logic [AW-1:0] base_d,
    output logic          busy,
    output logic          addr_valid,
    input  logic          addr_ready,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          last,
    output logic          done,
    output logic [AW-1:0] d_addr
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        STREAM,
        DONE
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [AW-1:0] i_q;
    logic [AW-1:0] j_q;
    logic [AW-1:0] n_q;
    logic [AW-1:0] ba_q;
    logic [AW-1:0] bb_q;
    logic [AW-1:0] bd_q;
    logic [AW-1:0] row_off_q;
    logic [AW-1:0] np1;
    // one extra bit so n = all-ones still yields 2^AW beats
    logic [AW:0]   cnt_q;
    logic [AW:0]   k_q;
    logic          is_last;

    assign np1     = n_q + AW'(1);
    assign is_last = (k_q == (cnt_q - (AW+1)'(1)));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    state_d = STREAM;
            STREAM:  if (addr_ready && is_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            n_q       <= '0;
            ba_q      <= '0;
            bb_q      <= '0;
            bd_q      <= '0;
            row_off_q <= '0;
            cnt_q     <= '0;
            k_q       <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        i_q  <= i_in;
                        j_q  <= j_in;
                        n_q  <= n_in;
                        ba_q <= base_a;
                        bb_q <= base_b;
                        bd_q <= base_d;
                        k_q  <= '0;
                    end
                end
                CALC: begin
                    cnt_q     <= {1'b0, n_q} + (AW+1)'(1);
                    row_off_q <= i_q * np1;
                end
                STREAM: begin
                    if (addr_ready && !is_last) k_q <= k_q + (AW+1)'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign addr_valid = (state_q == STREAM);
    assign last       = addr_valid && is_last;
    assign done       = (state_q == DONE);
    assign a_addr     = ba_q + row_off_q + k_q[AW-1:0];
    assign b_addr     = bb_q + k_q[AW-1:0];
    assign d_addr     = bd_q + j_q;

endmodule

// File: tb/tb_vec_addr_gen.sv
// Directed bench for vec_addr_gen: table of operations plus
// hand-written reset and start-ignore sequences.
module tb_vec_addr_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] i_in = '0;
    logic [31:0] j_in = '0;
    logic [31:0] n_in = '0;
    logic [31:0] base_a = '0;
    logic [31:0] base_b = '0;
    logic [31:0] base_d = '0;
    logic        addr_ready = 1'b1;
    logic        busy;
    logic        addr_valid;
    logic [31:0] a_addr;
    logic [31:0] b_addr;
    logic        last;
    logic        done;
    logic [31:0] d_addr;

    int errors = 0;
    int checks = 0;

    vec_addr_gen #(.AW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .i_in       (i_in),
        .j_in       (j_in),
        .n_in       (n_in),
        .base_a     (base_a),
        .base_b     (base_b),
        .base_d     (base_d),
        .busy       (busy),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .a_addr     (a_addr),
        .b_addr     (b_addr),
        .last       (last),
        .done       (done),
        .d_addr     (d_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] i;
        logic [31:0] j;
        logic [31:0] n;
        logic [31:0] ba;
        logic [31:0] bb;
        logic [31:0] bd;
        logic [31:0] exp_a0;
        logic [31:0] exp_b0;
        logic [31:0] exp_d;
        int          beats;
        int          stall_beat;
        int          stall_len;
        bit          start_in_done;
    } op_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input op_t op);
        int cyc;
        int beat;
        int stalled;
        int accepted;
        bit got_done;
        logic [31:0] ea;
        logic [31:0] eb;
        i_in   = op.i;
        j_in   = op.j;
        n_in   = op.n;
        base_a = op.ba;
        base_b = op.bb;
        base_d = op.bd;
        addr_ready = 1'b1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        // scramble inputs: captured copies must be used
        i_in   = 32'hDEAD_0001;
        j_in   = 32'hDEAD_0002;
        n_in   = 32'h0000_0007;
        base_a = 32'hDEAD_0003;
        base_b = 32'hDEAD_0004;
        base_d = 32'hDEAD_0005;
        cyc = 1;
        chk({op.name, " calc busy"}, 32'(busy), 32'd1);
        chk({op.name, " calc valid"}, 32'(addr_valid), 32'd0);
        beat = 0;
        stalled = 0;
        accepted = 0;
        got_done = 1'b0;
        while (cyc < 200) begin
            tick();
            cyc++;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (addr_valid) begin
                ea = op.exp_a0 + 32'(beat);
                eb = op.exp_b0 + 32'(beat);
                chk({op.name, " a_addr"}, a_addr, ea);
                chk({op.name, " b_addr"}, b_addr, eb);
                chk({op.name, " last"}, 32'(last),
                    32'(beat == op.beats - 1));
                if (beat == op.stall_beat && stalled < op.stall_len) begin
                    addr_ready = 1'b0;
                    stalled++;
                end else begin
                    addr_ready = 1'b1;
                    beat++;
                    accepted++;
                end
            end
        end
        chk({op.name, " done seen"}, 32'(got_done), 32'd1);
        chk({op.name, " beats"}, 32'(accepted), 32'(op.beats));
        chk({op.name, " cycles"}, 32'(cyc),
            32'(2 + op.beats + op.stall_len));
        chk({op.name, " d_addr"}, d_addr, op.exp_d);
        chk({op.name, " done valid"}, 32'(addr_valid), 32'd0);
        chk({op.name, " done busy"}, 32'(busy), 32'd1);
        if (op.start_in_done) start = 1'b1;
        tick();
        start = 1'b0;
        chk({op.name, " idle busy"}, 32'(busy), 32'd0);
        chk({op.name, " idle done"}, 32'(done), 32'd0);
        if (op.start_in_done) begin
            tick();
            chk({op.name, " ignored start busy"}, 32'(busy), 32'd0);
            tick();
            chk({op.name, " ignored start valid"}, 32'(addr_valid), 32'd0);
        end
    endtask

    op_t ops[5];
    op_t after_rst;

    initial begin
        ops[0] = '{"basic", 32'd2, 32'd5, 32'd3, 32'h100, 32'h200, 32'h300,
                   32'h108, 32'h200, 32'h305, 4, -1, 0, 1'b0};
        ops[1] = '{"bp", 32'd2, 32'd5, 32'd3, 32'h100, 32'h200, 32'h300,
                   32'h108, 32'h200, 32'h305, 4, 1, 3, 1'b0};
        ops[2] = '{"single", 32'd7, 32'd1, 32'd0, 32'h40, 32'h80, 32'h10,
                   32'h47, 32'h80, 32'h11, 1, -1, 0, 1'b1};
        ops[3] = '{"wrap", 32'd0, 32'h20, 32'd2, 32'hFFFF_FFFE,
                   32'hFFFF_FFFF, 32'hFFFF_FFF0,
                   32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h10, 3, -1, 0, 1'b0};
        ops[4] = '{"trunc", 32'h8000_0001, 32'd3, 32'd1, 32'h0, 32'h10,
                   32'h0, 32'h2, 32'h10, 32'h3, 2, 0, 1, 1'b0};
        after_rst = '{"postrst", 32'd1, 32'd0, 32'd1, 32'h1000, 32'h2000,
                      32'h3000, 32'h1002, 32'h2000, 32'h3000, 2, -1, 0,
                      1'b0};

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst valid", 32'(addr_valid), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst a_addr", a_addr, 32'd0);
        chk("rst b_addr", b_addr, 32'd0);
        chk("rst d_addr", d_addr, 32'd0);
        rst = 1'b1;
        tick();
        chk("post rst busy", 32'(busy), 32'd0);

        for (int t = 0; t < 5; t++) run_op(ops[t]);

        // mid-stream reset after the first beat
        i_in = 32'd2; j_in = 32'd5; n_in = 32'd3;
        base_a = 32'h100; base_b = 32'h200; base_d = 32'h300;
        addr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mid beat0 a", a_addr, 32'h108);
        tick();
        chk("mid beat1 a", a_addr, 32'h109);
        rst = 1'b0;
        #1;
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst valid", 32'(addr_valid), 32'd0);
        chk("mid rst last", 32'(last), 32'd0);
        chk("mid rst a", a_addr, 32'd0);
        chk("mid rst b", b_addr, 32'd0);
        chk("mid rst d", d_addr, 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mid rst no done", 32'(done), 32'd0);
        end
        rst = 1'b1;
        tick();
        chk("mid rst idle", 32'(busy), 32'd0);
        run_op(after_rst);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vec_addr_gen.md
# vec_addr_gen

Element address sequencer for the vector ASIP execute path. Sits directly downstream of the decode-stage scalar loop registers. When a MULF/SUMF instruction presents the loop scalars i, j and n, the block captures them with three base addresses. It then streams one operand-address pair per element to the vector memory port over a valid/ready handshake, and finally issues the destination address with a one-cycle done pulse.

## Interface
- AW, 32, address and scalar width in bits
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous reset, active-low (rst=0 resets immediately)
- start  input  1  request; honoured only in IDLE
- i_in, j_in, n_in  input  AW  loop scalars (row index, destination index, last element index)
- base_a, base_b, base_d  input  AW  base addresses for operand A, operand B and the result
- busy  output  1  high in every state except IDLE
- addr_valid  output  1  an address pair is presented
- addr_ready  input  1  consumer accepts the pair this cycle
- a_addr, b_addr  output  AW  operand addresses for the current element
- last  output  1  current pair is the final element
- done  output  1  one-cycle completion pulse
- d_addr  output  AW  result address; valid while done=1

## Operation
- States: IDLE, CALC, STREAM, DONE.
- IDLE:
  - On start=1, register i_in, j_in, n_in, base_a, base_b and base_d.
  - Clear element counter k to 0 and go to CALC.
  - start in any other state is ignored; it is not queued.
- CALC (exactly one cycle):
  - cnt = {1'b0, n} + 1 (AW+1 bits).
  - row_off = i × (n+1) mod 2^AW; product truncated to AW bits.
  - Go to STREAM.
- STREAM:
  - addr_valid=1.
  - a_addr = base_a + row_off + k (mod 2^AW).
  - b_addr = base_b + k (mod 2^AW).
  - last = (k == cnt−1).
  - On addr_valid & addr_ready: if last, go to DONE; else k increments.
  - While addr_ready=0, a_addr, b_addr and last hold stable.
- DONE (exactly one cycle):
  - done=1 and d_addr = base_d + j (mod 2^AW).
  - Go to IDLE.
- Element count is n+1. n=0 gives a single beat with last=1.
- n = 2^AW−1 gives cnt = 2^AW; k is AW+1 bits wide so this case does not wrap to zero beats. row_off = 0 because n+1 truncates to 0.
- All address arithmetic wraps silently; there is no overflow flag.
- Captured registers do not change during an operation, even if the inputs toggle.

## Timing
- Reset (rst=0, any time, including mid-stream):
  - State returns to IDLE immediately.
  - busy, addr_valid, last and done go to 0.
  - a_addr, b_addr and d_addr go to 0; k and the captured registers go to 0.
  - No partial completion is signalled.
- Start at edge t (IDLE): busy=1 and CALC in cycle t+1. First addr_valid=1 in cycle t+2.
- Throughput is one pair per cycle while addr_ready=1.
- Total cycles from start to done = 2 + (n+1) + stall cycles.
- Last handshake at edge u: done=1 in cycle u+1 (busy still 1). IDLE and busy=0 in cycle u+2. A start at edge u+2 is accepted.
- done is never high in the same cycle as addr_valid.
- Outputs are registered; no combinational path from addr_ready to addr_valid.

## Test plan
- Reset: hold rst=0, then release → busy=0, addr_valid=0, done=0, a_addr=b_addr=d_addr=0.
- Basic stream, ready=1:
  - Stimulus: i=2, j=5, n=3, base_a=0x100, base_b=0x200, base_d=0x300.
  - Pairs: (0x108,0x200), (0x109,0x201), (0x10A,0x202), (0x10B,0x203), with last only on the 4th.
  - Then done=1 with d_addr=0x305; 2+4 cycles from start to done.
- Backpressure, same stimulus: drop addr_ready for 3 cycles on beat 2 → a_addr=0x109 and b_addr=0x201 stay stable. Exactly 4 beats are accepted, and done arrives 3 cycles later than the ready=1 case.
- Single element:
  - n=0, i=7, base_a=0x40 → one beat a_addr=0x47, last=1, done the next cycle.
  - A start in the DONE cycle is ignored (busy stays low afterwards, no new stream).
- Wrap: base_a=0xFFFFFFFE, i=0, n=2 → a_addr sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Mid-stream reset: assert rst=0 after beat 1 of a 4-element op → outputs go to 0 at once and done never pulses. After release, a new start with n=1 streams 2 beats correctly.
